dma_ctrl: RTL and testbench

- Sprite-style DMA controller and bus arbiter between the mc6502 MPU and the system memory bus.
- A CPU write of a page number to a trigger register stalls the MPU through RDY, takes over the address/data bus, and copies 256 bytes from {page,8'h00..8'hFF} to a fixed destination port.
- Bus ownership returns to the MPU when the copy completes.
- Sits between the mpu instance and the memory/peripheral decoder in the top level.

---
 rtl/dma_ctrl.sv | 128 ++++++++++++
 tb/tb_dma_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_ctrl.sv
// rtl/dma_ctrl.sv - sprite DMA controller and MPU/memory bus arbiter
// Stalls the MPU via RDY and copies one 256-byte page to a fixed port.
module dma_ctrl #(
    parameter logic [15:0] REG_ADDR  = 16'h4014,
    parameter logic [15:0] DEST_ADDR = 16'h2004,
    parameter logic        ALIGN     = 1'b1
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CPU_R_W,
    input  logic [7:0] CPU_ABL,
    input  logic [7:0] CPU_ABH,
    input  logic [7:0] CPU_DB_OUT,
    input  logic [7:0] DB_IN,
    output logic       RDY,
    output logic       R_W,
    output logic [7:0] ABL,
    output logic [7:0] ABH,
    output logic [7:0] DB_OUT,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_data;
    logic       r_phase;
    logic       w_trigger;

    assign w_trigger = !CPU_R_W && ({CPU_ABH, CPU_ABL} == REG_ADDR);

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state <= S_IDLE;
            r_page  <= 8'h00;
            r_idx   <= 8'h00;
            r_data  <= 8'h00;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_phase <= ~r_phase;
            // only an idle controller may relatch the page
            if (r_state == S_IDLE && w_trigger) begin
                r_page <= CPU_DB_OUT;
                r_idx  <= 8'h00;
            end
            if (r_state == S_READ) begin
                r_data <= DB_IN;
            end
            if (r_state == S_WRITE) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_next_state = S_HALT;
                end
            end
            S_HALT: begin
                // the 6502 completes pending write cycles before it stops
                if (CPU_R_W) begin
                    if (!ALIGN || r_phase) begin
                        w_next_state = S_READ;
                    end else begin
                        w_next_state = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (r_phase) begin
                    w_next_state = S_READ;
                end
            end
            S_READ: begin
                w_next_state = S_WRITE;
            end
            S_WRITE: begin
                if (r_idx == 8'hFF) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_READ;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        RDY    = (r_state == S_IDLE);
        BUSY   = (r_state != S_IDLE);
        R_W    = CPU_R_W;
        ABL    = CPU_ABL;
        ABH    = CPU_ABH;
        DB_OUT = CPU_DB_OUT;
        case (r_state)
            S_READ: begin
                R_W = 1'b1;
                ABH = r_page;
                ABL = r_idx;
            end
            S_WRITE: begin
                R_W    = 1'b0;
                ABH    = DEST_ADDR[15:8];
                ABL    = DEST_ADDR[7:0];
                DB_OUT = r_data;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// tb/tb_dma_ctrl.sv - scoreboard bench for dma_ctrl (ALIGN=1 and ALIGN=0 instances)
module tb_dma_ctrl;

    localparam logic [15:0] DEST       = 16'h2004;
    localparam logic [15:0] STALL_ADDR = 16'hEEEE;

    logic       CLK = 1'b0;
    logic       RES = 1'b0;
    logic       CPU_R_W = 1'b1;
    logic [7:0] CPU_ABL = 8'hEE;
    logic [7:0] CPU_ABH = 8'hEE;
    logic [7:0] CPU_DB_OUT = 8'h00;

    logic [7:0] db_in_a, db_in_b;
    logic       rdy_a, rw_a, busy_a;
    logic [7:0] abl_a, abh_a, dbo_a;
    logic       rdy_b, rw_b, busy_b;
    logic [7:0] abl_b, abh_b, dbo_b;

    int k = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_t;
    bus_t exp_q[$];

    always #5 CLK = ~CLK;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    assign db_in_a = mem_byte({abh_a, abl_a});
    assign db_in_b = mem_byte({abh_b, abl_b});

    dma_ctrl #(.REG_ADDR(16'h4014), .DEST_ADDR(16'h2004), .ALIGN(1'b1)) u_dut (
        .CLK(CLK), .RES(RES), .CPU_R_W(CPU_R_W), .CPU_ABL(CPU_ABL), .CPU_ABH(CPU_ABH),
        .CPU_DB_OUT(CPU_DB_OUT), .DB_IN(db_in_a), .RDY(rdy_a), .R_W(rw_a),
        .ABL(abl_a), .ABH(abh_a), .DB_OUT(dbo_a), .BUSY(busy_a)
    );

    dma_ctrl #(.REG_ADDR(16'h4014), .DEST_ADDR(16'h2004), .ALIGN(1'b0)) u_dut_na (
        .CLK(CLK), .RES(RES), .CPU_R_W(CPU_R_W), .CPU_ABL(CPU_ABL), .CPU_ABH(CPU_ABH),
        .CPU_DB_OUT(CPU_DB_OUT), .DB_IN(db_in_b), .RDY(rdy_b), .R_W(rw_b),
        .ABL(abl_b), .ABH(abh_b), .DB_OUT(dbo_b), .BUSY(busy_b)
    );

    // edges since reset release; its parity is the DUT phase during a cycle
    always @(posedge CLK or posedge RES) begin
        if (RES) k <= 0;
        else     k <= k + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // monitor: every stalled cycle is either CPU pass-through or a scoreboarded DMA cycle
    always @(negedge CLK) begin
        bus_t e;
        if (!RES && rdy_a === 1'b0) begin
            if ({abh_a, abl_a} == STALL_ADDR) begin
                chk("halt_passthru", {23'd0, rw_a, dbo_a}, {23'd0, CPU_R_W, CPU_DB_OUT});
            end else if (exp_q.size() == 0) begin
                chk("dma_cycle_expected", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("dma_rw", {31'd0, rw_a}, {31'd0, e.rw});
                chk("dma_addr", {16'd0, abh_a, abl_a}, {16'd0, e.addr});
                if (e.rw) chk("read_phase_even", k % 2, 0);
                else      chk("dma_wdata", {24'd0, dbo_a}, {24'd0, e.data});
            end
        end
    end

    task automatic cpu_idle();
        CPU_R_W = 1'b1;
        {CPU_ABH, CPU_ABL} = STALL_ADDR;
        CPU_DB_OUT = 8'h55;
    endtask

    task automatic trigger(input logic [7:0] pg, input int par);
        @(posedge CLK); #1;
        while (k % 2 != par) begin
            @(posedge CLK); #1;
        end
        CPU_R_W = 1'b0;
        {CPU_ABH, CPU_ABL} = 16'h4014;
        CPU_DB_OUT = pg;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(bus_t'({1'b1, pg, i[7:0], 8'h00}));
            exp_q.push_back(bus_t'({1'b0, DEST, mem_byte({pg, i[7:0]})}));
        end
        @(negedge CLK);
        chk("trigger_cycle_rdy", {31'd0, rdy_a}, 1);
        chk("trigger_cycle_addr", {16'd0, abh_a, abl_a}, 32'h4014);
        chk("trigger_cycle_rw", {31'd0, rw_a}, 0);
    endtask

    task automatic run_xfer(input logic [7:0] pg, input int par, input int extra,
                            input int exp_a, input int exp_b);
        int ca = 0;
        int cb = 0;
        bit done = 0;
        trigger(pg, par);
        for (int c = 0; c < 1200 && !done; c++) begin
            @(posedge CLK); #1;
            if (extra > 0) begin
                CPU_R_W = 1'b0;
                {CPU_ABH, CPU_ABL} = STALL_ADDR;
                CPU_DB_OUT = 8'hA0 + extra[7:0];
                extra--;
            end else begin
                cpu_idle();
            end
            @(negedge CLK);
            if (!rdy_a) ca++;
            if (!rdy_b) cb++;
            if (rdy_a && rdy_b) done = 1;
        end
        chk("xfer_done", {31'd0, done}, 1);
        chk("stall_cycles_align", ca, exp_a);
        chk("stall_cycles_noalign", cb, exp_b);
        chk("busy_a_idle", {31'd0, busy_a}, 0);
        chk("busy_b_idle", {31'd0, busy_b}, 0);
        chk("idle_passthru_addr", {16'd0, abh_a, abl_a}, {16'd0, STALL_ADDR});
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic passthru_cycle(input logic rw, input logic [15:0] addr, input logic [7:0] d);
        @(posedge CLK); #1;
        CPU_R_W = rw;
        {CPU_ABH, CPU_ABL} = addr;
        CPU_DB_OUT = d;
        @(negedge CLK);
        chk("nontrig_rdy_a", {31'd0, rdy_a}, 1);
        chk("nontrig_rdy_b", {31'd0, rdy_b}, 1);
        chk("nontrig_busy", {31'd0, busy_a}, 0);
        chk("nontrig_addr", {16'd0, abh_a, abl_a}, {16'd0, addr});
        chk("nontrig_rw", {31'd0, rw_a}, {31'd0, rw});
        chk("nontrig_data", {24'd0, dbo_a}, {24'd0, d});
    endtask

    task automatic reset_mid_write();
        int nw = 0;
        bit hit = 0;
        trigger(8'h02, 0);
        for (int c = 0; c < 600 && !hit; c++) begin
            @(posedge CLK); #1;
            cpu_idle();
            @(negedge CLK);
            if (!rdy_a && !rw_a && {abh_a, abl_a} == DEST) begin
                nw++;
                if (nw == 100) hit = 1;
            end
        end
        chk("reached_100th_write", {31'd0, hit}, 1);
        #2 RES = 1'b1;
        #1;
        chk("res_rdy_a", {31'd0, rdy_a}, 1);
        chk("res_rdy_b", {31'd0, rdy_b}, 1);
        chk("res_busy", {31'd0, busy_a}, 0);
        chk("res_addr", {16'd0, abh_a, abl_a}, {16'd0, STALL_ADDR});
        chk("res_rw", {31'd0, rw_a}, 1);
        chk("res_data", {24'd0, dbo_a}, 32'h55);
        exp_q.delete();
        @(posedge CLK); #1;
        RES = 1'b0;
    endtask

    initial begin
        cpu_idle();
        #1 RES = 1'b1;
        #1;
        chk("reset_rdy", {31'd0, rdy_a}, 1);
        chk("reset_busy", {31'd0, busy_a}, 0);
        chk("reset_passthru_addr", {16'd0, abh_a, abl_a}, {16'd0, STALL_ADDR});
        chk("reset_passthru_data", {24'd0, dbo_a}, 32'h55);
        repeat (2) @(posedge CLK);
        #1 RES = 1'b0;

        run_xfer(8'h02, 0, 0, 513, 513);
        run_xfer(8'h02, 1, 0, 514, 513);
        run_xfer(8'h05, 0, 2, 515, 515);
        run_xfer(8'hFF, 1, 2, 516, 515);
        reset_mid_write();
        run_xfer(8'h03, 0, 0, 513, 513);

        passthru_cycle(1'b0, 16'h4015, 8'h07);
        passthru_cycle(1'b1, 16'h4014, 8'h09);
        passthru_cycle(1'b1, 16'h1234, 8'h00);
        chk("nontrig_no_dma", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
